multicycle_main_ctrl: RTL and testbench

Main control unit for the multi-cycle MIPS datapath. It is the producer of the 3-bit ALUOp code that the ALU controller consumes, so it sits at the other end of that interface. A Moore FSM steps each instruction through fetch, decode, execute, memory and writeback, and drives the datapath enables. It waits on a memory-ready handshake during fetch, load and store.

---
 rtl/multicycle_main_ctrl_if.sv | 44 ++++
 rtl/multicycle_main_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_multicycle_main_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_main_ctrl_if.sv
// Control bundle between the multi-cycle main controller and the datapath.
// The controller is the master: it takes the opcode and memory-ready
// handshake and drives every datapath enable.
// Optional feature macro: INSTR_CNT_EN adds the retired-instruction count.
interface multicycle_main_ctrl_if;
  logic [5:0]  instr_op_i;
  logic        mem_ready_i;
  logic [2:0]  ALUOp_o;
  logic        ALUSrc_o;
  logic        RegDst_o;
  logic        RegWrite_o;
  logic        MemRead_o;
  logic        MemWrite_o;
  logic        MemtoReg_o;
  logic        IRWrite_o;
  logic        PCWrite_o;
  logic        Branch_o;
  logic        illegal_o;
  logic        done_o;
  logic [3:0]  state_o;
`ifdef INSTR_CNT_EN
  logic [31:0] instr_cnt_o;
`endif

  modport master (
    input  instr_op_i, mem_ready_i,
    output ALUOp_o, ALUSrc_o, RegDst_o, RegWrite_o, MemRead_o, MemWrite_o,
           MemtoReg_o, IRWrite_o, PCWrite_o, Branch_o, illegal_o, done_o,
           state_o
`ifdef INSTR_CNT_EN
    , output instr_cnt_o
`endif
  );

  modport slave (
    output instr_op_i, mem_ready_i,
    input  ALUOp_o, ALUSrc_o, RegDst_o, RegWrite_o, MemRead_o, MemWrite_o,
           MemtoReg_o, IRWrite_o, PCWrite_o, Branch_o, illegal_o, done_o,
           state_o
`ifdef INSTR_CNT_EN
    , input instr_cnt_o
`endif
  );
endinterface

// File: rtl/multicycle_main_ctrl.sv
// Main control FSM of the multi-cycle MIPS datapath: fetch, decode,
// execute, memory and writeback, with a memory-ready stall in fetch,
// load and store. Produces the 3-bit ALUOp consumed by the ALU controller.
// Optional feature macro: INSTR_CNT_EN (32-bit retired-instruction counter).
module multicycle_main_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'd0,
  parameter logic [5:0] OP_ADDI  = 6'd8,
  parameter logic [5:0] OP_BEQ   = 6'd4,
  parameter logic [5:0] OP_LW    = 6'd35,
  parameter logic [5:0] OP_SW    = 6'd43
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  multicycle_main_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_EXR  = 4'd2,
    S_WBR  = 4'd3,
    S_EXI  = 4'd4,
    S_WBI  = 4'd5,
    S_BR   = 4'd6,
    S_ADDR = 4'd7,
    S_MRD  = 4'd8,
    S_WBL  = 4'd9,
    S_MWR  = 4'd10
  } state_t;

  state_t     state_r;
  state_t     state_next_s;
  logic [5:0] op_r;

  logic [2:0] alu_op_s;
  logic       alu_src_s;
  logic       reg_dst_s;
  logic       reg_write_s;
  logic       mem_read_s;
  logic       mem_write_s;
  logic       mem_to_reg_s;
  logic       ir_write_s;
  logic       pc_write_s;
  logic       branch_s;
  logic       illegal_s;
  logic       done_s;

  // State register and opcode latch; op_r captures the opcode while decoding.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r <= S_IF;
      op_r    <= 6'd0;
    end else begin
      state_r <= state_next_s;
      if (state_r == S_ID) begin
        op_r <= bus.instr_op_i;
      end else begin
        op_r <= op_r;
      end
    end
  end

  // Next-state and control decode; every output defaults to 0 with ALUOp = add.
  always_comb begin
    state_next_s = S_IF;
    alu_op_s     = 3'b010;
    alu_src_s    = 1'b0;
    reg_dst_s    = 1'b0;
    reg_write_s  = 1'b0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    mem_to_reg_s = 1'b0;
    ir_write_s   = 1'b0;
    pc_write_s   = 1'b0;
    branch_s     = 1'b0;
    illegal_s    = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      S_IF: begin
        mem_read_s = 1'b1;
        if (bus.mem_ready_i) begin
          ir_write_s   = 1'b1;
          pc_write_s   = 1'b1;
          state_next_s = S_ID;
        end else begin
          state_next_s = S_IF;
        end
      end
      S_ID: begin
        // Opcode comes straight from the IR here; op_r is loaded at this edge.
        case (bus.instr_op_i)
          OP_RTYPE:     state_next_s = S_EXR;
          OP_ADDI:      state_next_s = S_EXI;
          OP_BEQ:       state_next_s = S_BR;
          OP_LW, OP_SW: state_next_s = S_ADDR;
          default: begin
            illegal_s    = 1'b1;
            done_s       = 1'b1;
            state_next_s = S_IF;
          end
        endcase
      end
      S_EXR: begin
        alu_op_s     = 3'b000;
        state_next_s = S_WBR;
      end
      S_WBR: begin
        reg_write_s = 1'b1;
        reg_dst_s   = 1'b1;
        done_s      = 1'b1;
      end
      S_EXI: begin
        alu_src_s    = 1'b1;
        state_next_s = S_WBI;
      end
      S_WBI: begin
        reg_write_s = 1'b1;
        done_s      = 1'b1;
      end
      S_BR: begin
        alu_op_s = 3'b001;
        branch_s = 1'b1;
        done_s   = 1'b1;
      end
      S_ADDR: begin
        alu_src_s = 1'b1;
        if (op_r == OP_LW) begin
          state_next_s = S_MRD;
        end else if (op_r == OP_SW) begin
          state_next_s = S_MWR;
        end else begin
          state_next_s = S_IF;
        end
      end
      S_MRD: begin
        mem_read_s = 1'b1;
        if (bus.mem_ready_i) begin
          state_next_s = S_WBL;
        end else begin
          state_next_s = S_MRD;
        end
      end
      S_WBL: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
        done_s       = 1'b1;
      end
      S_MWR: begin
        mem_write_s = 1'b1;
        if (bus.mem_ready_i) begin
          done_s       = 1'b1;
          state_next_s = S_IF;
        end else begin
          state_next_s = S_MWR;
        end
      end
      default: begin
        // Unused encodings: everything quiet, recover to fetch.
        alu_op_s     = 3'b000;
        state_next_s = S_IF;
      end
    endcase
  end

  // Reset low silences every control line immediately, aborting any access.
  assign bus.ALUOp_o    = rst_i ? alu_op_s     : 3'b000;
  assign bus.ALUSrc_o   = rst_i & alu_src_s;
  assign bus.RegDst_o   = rst_i & reg_dst_s;
  assign bus.RegWrite_o = rst_i & reg_write_s;
  assign bus.MemRead_o  = rst_i & mem_read_s;
  assign bus.MemWrite_o = rst_i & mem_write_s;
  assign bus.MemtoReg_o = rst_i & mem_to_reg_s;
  assign bus.IRWrite_o  = rst_i & ir_write_s;
  assign bus.PCWrite_o  = rst_i & pc_write_s;
  assign bus.Branch_o   = rst_i & branch_s;
  assign bus.illegal_o  = rst_i & illegal_s;
  assign bus.done_o     = rst_i & done_s;
  assign bus.state_o    = rst_i ? state_r      : 4'd0;

`ifdef INSTR_CNT_EN
  logic [31:0] instr_cnt_r;

  // Count retired legal instructions; wraps naturally at 32 bits.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      instr_cnt_r <= 32'd0;
    end else if (done_s && !illegal_s) begin
      instr_cnt_r <= instr_cnt_r + 32'd1;
    end else begin
      instr_cnt_r <= instr_cnt_r;
    end
  end

  assign bus.instr_cnt_o = instr_cnt_r;
`endif

endmodule

// File: tb/tb_multicycle_main_ctrl.sv
// Scoreboard bench for multicycle_main_ctrl. The driver issues instructions
// with random opcodes and memory stall counts, pushing an instruction-level
// expectation (cycle count and per-signal active-cycle tallies) derived from
// the state sequence of each instruction class. A monitor tallies the DUT
// outputs and compares on every done_o pulse.
module tb_multicycle_main_ctrl;

  logic clk;
  logic rst_n;

  multicycle_main_ctrl_if bus_if ();

  multicycle_main_ctrl dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cycles; int mr; int mw; int rw; int irw; int pcw; int br;
    int a0; int a1; int a2; int src; int rdst; int m2r; int ill; int first;
  } rec_t;

  rec_t sb_q[$];
  rec_t acc;
  int   n_cmp;
  int   n_err;
  int   legal_cnt;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected tallies from the instruction class: fetch (f stalls), decode,
  // then class-specific execute/memory/writeback phases.
  function automatic rec_t model(input logic [5:0] op, input int f, input int m);
    rec_t e = '{default: 0};
    e.mr = f + 1; e.irw = 1; e.pcw = 1;
    case (op)
      6'd0:  begin e.cycles = f + 4; e.a0 = 1; e.rw = 1; e.rdst = 1; end
      6'd8:  begin e.cycles = f + 4; e.src = 1; e.rw = 1; end
      6'd4:  begin e.cycles = f + 3; e.a1 = 1; e.br = 1; end
      6'd35: begin e.cycles = f + m + 5; e.src = 1; e.mr += m + 1; e.rw = 1; e.m2r = 1; end
      6'd43: begin e.cycles = f + m + 4; e.src = 1; e.mw = m + 1; end
      default: begin e.cycles = f + 2; e.ill = 1; end
    endcase
    e.a2 = e.cycles - e.a0 - e.a1;
    return e;
  endfunction

  // Drive one instruction cycle by cycle; mem_ready follows the stall plan in
  // waiting states and is random where it must be ignored.
  task automatic issue(input logic [5:0] op, input int f, input int m);
    rec_t e = model(op, f, m);
    int   mem_at = -1;
    if (op == 6'd35 || op == 6'd43) mem_at = f + 3;
    sb_q.push_back(e);
    if (e.ill == 0) legal_cnt++;
    for (int c = 0; c < e.cycles; c++) begin
      bus_if.instr_op_i = op;
      if (c < f) bus_if.mem_ready_i = 1'b0;
      else if (c == f) bus_if.mem_ready_i = 1'b1;
      else if (mem_at >= 0 && c >= mem_at) bus_if.mem_ready_i = (c == mem_at + m);
      else bus_if.mem_ready_i = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int ctrl_vec();
    return int'({bus_if.ALUOp_o, bus_if.ALUSrc_o, bus_if.RegDst_o, bus_if.RegWrite_o,
                 bus_if.MemRead_o, bus_if.MemWrite_o, bus_if.MemtoReg_o, bus_if.IRWrite_o,
                 bus_if.PCWrite_o, bus_if.Branch_o, bus_if.illegal_o, bus_if.done_o,
                 bus_if.state_o});
  endfunction

  // Monitor: tally outputs per instruction, compare against the scoreboard on done_o.
  always @(negedge clk) begin
    rec_t e;
    if (!rst_n) begin
      acc = '{default: 0};
    end else begin
      if (acc.cycles == 0) acc.first = int'(bus_if.state_o);
      acc.cycles++;
      acc.mr   += int'(bus_if.MemRead_o);
      acc.mw   += int'(bus_if.MemWrite_o);
      acc.rw   += int'(bus_if.RegWrite_o);
      acc.irw  += int'(bus_if.IRWrite_o);
      acc.pcw  += int'(bus_if.PCWrite_o);
      acc.br   += int'(bus_if.Branch_o);
      acc.src  += int'(bus_if.ALUSrc_o);
      acc.rdst += int'(bus_if.RegDst_o);
      acc.m2r  += int'(bus_if.MemtoReg_o);
      acc.ill  += int'(bus_if.illegal_o);
      if (bus_if.ALUOp_o == 3'b000) acc.a0++;
      else if (bus_if.ALUOp_o == 3'b001) acc.a1++;
      else if (bus_if.ALUOp_o == 3'b010) acc.a2++;
      if (bus_if.done_o) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("cycles", acc.cycles, e.cycles);
          check("first_state", acc.first, 0);
          check("memread_cycles", acc.mr, e.mr);
          check("memwrite_cycles", acc.mw, e.mw);
          check("regwrite_cycles", acc.rw, e.rw);
          check("irwrite_cycles", acc.irw, e.irw);
          check("pcwrite_cycles", acc.pcw, e.pcw);
          check("branch_cycles", acc.br, e.br);
          check("aluop000_cycles", acc.a0, e.a0);
          check("aluop001_cycles", acc.a1, e.a1);
          check("aluop010_cycles", acc.a2, e.a2);
          check("alusrc_cycles", acc.src, e.src);
          check("regdst_cycles", acc.rdst, e.rdst);
          check("memtoreg_cycles", acc.m2r, e.m2r);
          check("illegal_cycles", acc.ill, e.ill);
        end
        acc = '{default: 0};
      end
    end
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] op;
    int         pick;
    n_cmp = 0; n_err = 0; legal_cnt = 0;
    acc = '{default: 0};
    rst_n = 1'b0;
    bus_if.instr_op_i  = 6'd0;
    bus_if.mem_ready_i = 1'b1;
    @(negedge clk);
    check("reset_outputs", ctrl_vec(), 0);
    @(posedge clk);
    @(negedge clk);
    check("reset_outputs_hold", ctrl_vec(), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed instructions from the plan.
    issue(6'd0, 0, 0);
    issue(6'd35, 0, 2);
    issue(6'd4, 1, 0);
    issue(6'd63, 0, 0);
    issue(6'd43, 2, 1);
    issue(6'd8, 0, 0);

    // Randomized instruction stream.
    for (int i = 0; i < 60; i++) begin
      pick = $urandom_range(0, 5);
      case (pick)
        0: op = 6'd0;
        1: op = 6'd8;
        2: op = 6'd4;
        3: op = 6'd35;
        4: op = 6'd43;
        default: begin
          op = 6'($urandom_range(0, 63));
          while (op == 6'd0 || op == 6'd8 || op == 6'd4 || op == 6'd35 || op == 6'd43)
            op = 6'($urandom_range(0, 63));
        end
      endcase
      issue(op, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    check("scoreboard_drain", sb_q.size(), 0);

    // Reset during a stalled store: write enable must drop immediately.
    sb_q.delete();
    bus_if.instr_op_i = 6'd43;
    bus_if.mem_ready_i = 1'b1;
    @(posedge clk); #1;
    bus_if.mem_ready_i = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    check("sw_mwr_memwrite", int'(bus_if.MemWrite_o), 1);
    check("sw_mwr_state", int'(bus_if.state_o), 10);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_memwrite", int'(bus_if.MemWrite_o), 0);
    check("abort_state", int'(bus_if.state_o), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    legal_cnt = 0;
    @(negedge clk);
    check("after_abort_state", int'(bus_if.state_o), 0);
    check("after_abort_memwrite", int'(bus_if.MemWrite_o), 0);
    @(posedge clk); #1;
    // The S_IF cycle above saw mem_ready low; restart cleanly from fetch.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    acc = '{default: 0};

    issue(6'd0, 0, 0);
    issue(6'd8, 0, 0);
    issue(6'd63, 0, 0);
    issue(6'd35, 0, 0);
    check("scoreboard_drain_final", sb_q.size(), 0);
`ifdef INSTR_CNT_EN
    @(negedge clk);
    check("instr_cnt", int'(bus_if.instr_cnt_o), legal_cnt);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
